// File: rtl/writeback_stage_if.sv
// writeback_stage_if
//   Bundles the EX_WB stage register fields, the two decode read ports, the
//   forwarding register outputs and the retired-op counter of writeback_stage.
//   master : ALU/decode side (drives EX_WB fields and read addresses)
//   slave  : writeback_stage (drives read data, forward register, instret)
//   EX_WB fields: alu_result, alu_result_ready, do_not_execute, reg_wr_addr, reg_wr_en
interface writeback_stage_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5
);
  logic [XLEN-1:0]   alu_result;
  logic              alu_result_ready;
  logic              do_not_execute;
  logic [ADDR_W-1:0] reg_wr_addr;
  logic              reg_wr_en;

  logic [ADDR_W-1:0] rs1_addr;
  logic [ADDR_W-1:0] rs2_addr;
  logic [XLEN-1:0]   rs1_data;
  logic [XLEN-1:0]   rs2_data;

  logic              fwd_valid;
  logic [ADDR_W-1:0] fwd_addr;
  logic [XLEN-1:0]   fwd_data;

  logic [63:0]       instret;

  modport master (
    output alu_result, alu_result_ready, do_not_execute, reg_wr_addr, reg_wr_en,
    output rs1_addr, rs2_addr,
    input  rs1_data, rs2_data, fwd_valid, fwd_addr, fwd_data, instret
  );

  modport slave (
    input  alu_result, alu_result_ready, do_not_execute, reg_wr_addr, reg_wr_en,
    input  rs1_addr, rs2_addr,
    output rs1_data, rs2_data, fwd_valid, fwd_addr, fwd_data, instret
  );
endinterface

// File: rtl/writeback_stage.sv
// writeback_stage
//   Final pipeline stage: commits EX_WB results into the integer register file
//   (x0 hardwired to zero), serves two combinational read ports with
//   same-cycle write-through bypass, and registers the last commit for one
//   cycle so the ALU operand muxes can forward it.
// Ports
//   clk      : clock, all state updates on posedge
//   reset_n  : asynchronous active-low reset
//   wb       : writeback_stage_if.slave (EX_WB fields, rs1/rs2 read ports,
//              fwd_valid/fwd_addr/fwd_data, instret)
// Configuration
//   WB_INSTRET_EN : when defined, adds a 64-bit retired-op counter on
//                   wb.instret; otherwise wb.instret is tied to 0.
module writeback_stage #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input logic               clk,
  input logic               reset_n,
  writeback_stage_if.slave  wb
);

  logic [XLEN-1:0]   regs_q [NUM_REGS];
  logic [XLEN-1:0]   regs_d [NUM_REGS];
  logic              fwd_valid_q, fwd_valid_d;
  logic [ADDR_W-1:0] fwd_addr_q,  fwd_addr_d;
  logic [XLEN-1:0]   fwd_data_q,  fwd_data_d;

  logic wr_in_range;
  logic rs1_in_range;
  logic rs2_in_range;
  logic commit;

  // Addresses beyond NUM_REGS exist only when NUM_REGS < 2**ADDR_W.
  assign wr_in_range  = (32'(wb.reg_wr_addr) < 32'(NUM_REGS));
  assign rs1_in_range = (32'(wb.rs1_addr)    < 32'(NUM_REGS));
  assign rs2_in_range = (32'(wb.rs2_addr)    < 32'(NUM_REGS));

  assign commit = wb.alu_result_ready & wb.reg_wr_en & ~wb.do_not_execute &
                  (wb.reg_wr_addr != '0) & wr_in_range;

  always_comb begin
    regs_d      = regs_q;
    fwd_valid_d = commit;
    fwd_addr_d  = fwd_addr_q;
    fwd_data_d  = fwd_data_q;
    if (commit) begin
      regs_d[wb.reg_wr_addr] = wb.alu_result;
      fwd_addr_d             = wb.reg_wr_addr;
      fwd_data_d             = wb.alu_result;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      fwd_valid_q <= 1'b0;
      fwd_addr_q  <= '0;
      fwd_data_q  <= '0;
    end else begin
      regs_q      <= regs_d;
      fwd_valid_q <= fwd_valid_d;
      fwd_addr_q  <= fwd_addr_d;
      fwd_data_q  <= fwd_data_d;
    end
  end

  // x0 and out-of-range reads win over the bypass; commit already excludes
  // both, so the bypass only ever targets a real, writable register.
  assign wb.rs1_data = (wb.rs1_addr == '0 || !rs1_in_range) ? '0 :
                       (commit && wb.rs1_addr == wb.reg_wr_addr) ? wb.alu_result :
                       regs_q[wb.rs1_addr];
  assign wb.rs2_data = (wb.rs2_addr == '0 || !rs2_in_range) ? '0 :
                       (commit && wb.rs2_addr == wb.reg_wr_addr) ? wb.alu_result :
                       regs_q[wb.rs2_addr];

  assign wb.fwd_valid = fwd_valid_q;
  assign wb.fwd_addr  = fwd_addr_q;
  assign wb.fwd_data  = fwd_data_q;

`ifdef WB_INSTRET_EN
  logic [63:0] instret_q, instret_d;

  // Every executed op retires, including ones that write nothing or target x0.
  always_comb begin
    instret_d = instret_q;
    if (wb.alu_result_ready && !wb.do_not_execute) instret_d = instret_q + 64'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) instret_q <= '0;
    else          instret_q <= instret_d;
  end

  assign wb.instret = instret_q;
`else
  assign wb.instret = '0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  writeback_stage_if #(.XLEN(32), .ADDR_W(5)) wbi ();

  writeback_stage #(.XLEN(32), .NUM_REGS(32), .ADDR_W(5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .wb      (wbi.slave)
  );

  typedef struct {
    logic [31:0] e1;
    logic [31:0] e2;
    logic        efv;
    logic        chk_fwd;
    logic [4:0]  efa;
    logic [31:0] efd;
    logic [63:0] eir;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] ir_model = '0;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: each negedge with a pending entry, compare the DUT outputs.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      cmp("rs1_data",  64'(wbi.rs1_data),  64'(e.e1));
      cmp("rs2_data",  64'(wbi.rs2_data),  64'(e.e2));
      cmp("fwd_valid", 64'(wbi.fwd_valid), 64'(e.efv));
      if (e.chk_fwd) begin
        cmp("fwd_addr", 64'(wbi.fwd_addr), 64'(e.efa));
        cmp("fwd_data", 64'(wbi.fwd_data), 64'(e.efd));
      end
      cmp("instret", wbi.instret, e.eir);
    end
  end

  // One cycle of stimulus: drive right after posedge, push the expectation
  // that holds until the next posedge.
  task automatic step(input logic rn, input logic rdy, input logic dne, input logic wen,
                      input logic [4:0] wa, input logic [31:0] wd,
                      input logic [4:0] a1, input logic [4:0] a2,
                      input logic [31:0] e1, input logic [31:0] e2,
                      input logic efv, input logic chk,
                      input logic [4:0] efa, input logic [31:0] efd);
    exp_t e;
    @(posedge clk);
    #1;
    reset_n              = rn;
    wbi.alu_result_ready = rdy;
    wbi.do_not_execute   = dne;
    wbi.reg_wr_en        = wen;
    wbi.reg_wr_addr      = wa;
    wbi.alu_result       = wd;
    wbi.rs1_addr         = a1;
    wbi.rs2_addr         = a2;
    if (!rn) ir_model = '0;
    e.e1 = e1; e.e2 = e2; e.efv = efv; e.chk_fwd = chk;
    e.efa = efa; e.efd = efd; e.eir = ir_model;
    sb.push_back(e);
`ifdef WB_INSTRET_EN
    if (rn && rdy && !dne) ir_model = ir_model + 64'd1;
`endif
  endtask

  initial begin
    wbi.alu_result_ready = 1'b0;
    wbi.do_not_execute   = 1'b0;
    wbi.reg_wr_en        = 1'b0;
    wbi.reg_wr_addr      = '0;
    wbi.alu_result       = '0;
    wbi.rs1_addr         = '0;
    wbi.rs2_addr         = '0;

    // Reset state
    step(0,0,0,0, 5'd0, 32'h0, 5'd1, 5'd2, 32'h0, 32'h0, 0,1, 5'd0, 32'h0);
    step(1,0,0,0, 5'd0, 32'h0, 5'd3, 5'd4, 32'h0, 32'h0, 0,1, 5'd0, 32'h0);
    for (int i = 0; i < 32; i++)
      step(1,0,0,0, 5'd0, 32'h0, 5'(i), 5'(31-i), 32'h0, 32'h0, 0,1, 5'd0, 32'h0);

    // x5 commit with bypass, then array and forward register
    step(1,1,0,1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 0,1, 5'd0, 32'h0);
    step(1,0,0,0, 5'd0, 32'h0, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 1,1, 5'd5, 32'hDEADBEEF);

    // x0 is never written; forward register holds
    step(1,1,0,1, 5'd0, 32'h12345678, 5'd0, 5'd0, 32'h0, 32'h0, 0,1, 5'd5, 32'hDEADBEEF);
    step(1,0,0,0, 5'd0, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0, 0,1, 5'd5, 32'hDEADBEEF);

    // Bubbles: do_not_execute, then alu_result_ready low
    step(1,1,1,1, 5'd7, 32'h1, 5'd7, 5'd5, 32'h0, 32'hDEADBEEF, 0,1, 5'd5, 32'hDEADBEEF);
    step(1,0,0,1, 5'd7, 32'h1, 5'd7, 5'd7, 32'h0, 32'h0, 0,1, 5'd5, 32'hDEADBEEF);
    step(1,0,0,0, 5'd0, 32'h0, 5'd7, 5'd7, 32'h0, 32'h0, 0,1, 5'd5, 32'hDEADBEEF);

    // Back-to-back commits to x3
    step(1,1,0,1, 5'd3, 32'hA, 5'd0, 5'd3, 32'h0, 32'hA, 0,1, 5'd5, 32'hDEADBEEF);
    step(1,1,0,1, 5'd3, 32'hB, 5'd0, 5'd3, 32'h0, 32'hB, 1,1, 5'd3, 32'hA);
    step(1,0,0,0, 5'd0, 32'h0, 5'd5, 5'd3, 32'hDEADBEEF, 32'hB, 1,1, 5'd3, 32'hB);

    // Reset mid-stream takes effect at once; a commit during reset only bypasses
    step(0,0,0,0, 5'd0, 32'h0, 5'd3, 5'd5, 32'h0, 32'h0, 0,1, 5'd0, 32'h0);
    step(0,1,0,1, 5'd9, 32'h99, 5'd9, 5'd3, 32'h99, 32'h0, 0,1, 5'd0, 32'h0);
    step(1,0,0,0, 5'd0, 32'h0, 5'd9, 5'd3, 32'h0, 32'h0, 0,1, 5'd0, 32'h0);

    // First commit after reset, then a non-writing op
    step(1,1,0,1, 5'd9, 32'h55, 5'd9, 5'd0, 32'h55, 32'h0, 0,1, 5'd0, 32'h0);
    step(1,0,0,0, 5'd0, 32'h0, 5'd9, 5'd9, 32'h55, 32'h55, 1,1, 5'd9, 32'h55);
    step(1,1,0,0, 5'd4, 32'h44, 5'd4, 5'd9, 32'h0, 32'h55, 0,1, 5'd9, 32'h55);
    step(1,0,0,0, 5'd0, 32'h0, 5'd4, 5'd9, 32'h0, 32'h55, 0,1, 5'd9, 32'h55);

`ifdef WB_INSTRET_EN
    begin
      logic prev;
      step(0,0,0,0, 5'd0, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0, 0,1, 5'd0, 32'h0);
      step(1,0,0,0, 5'd0, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0, 0,1, 5'd0, 32'h0);
      prev = 1'b0;
      // 12 entries: bubbles at 4 and 8, reg_wr_en=0 at 1, 5, 9
      for (int i = 0; i < 12; i++) begin
        logic rdy, dne, wen;
        rdy = (i != 4);
        dne = (i == 8);
        wen = !(i == 1 || i == 5 || i == 9);
        step(1, rdy, dne, wen, 5'(10 + i % 5), 32'(i), 5'd0, 5'd0,
             32'h0, 32'h0, prev, 0, 5'd0, 32'h0);
        prev = rdy && !dne && wen;
      end
      step(1,0,0,0, 5'd0, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0, prev,0, 5'd0, 32'h0);
      @(negedge clk);
      #1;
      force dut.instret_q = '1;
      #1;
      release dut.instret_q;
      ir_model = '1;
      step(1,1,0,0, 5'd0, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0, 0,0, 5'd0, 32'h0);
      step(1,0,0,0, 5'd0, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0, 0,0, 5'd0, 32'h0);
    end
`endif

    begin
      int budget;
      budget = 0;
      while (sb.size() > 0 && budget < 10) begin
        @(negedge clk);
        budget++;
      end
      #1;
      if (sb.size() > 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL drain: %0d entries left, 0 required", sb.size());
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
